// File: rtl/jtag_mbox_ctrl.sv
// JTAG mailbox controller.
// A 16-bit TAP data register (selected by MBOX_IR) captures a status word and,
// on update, queues a command {write, addr[6:0], wdata[7:0]} into a small FIFO.
// A drain FSM issues queued commands to a register bank and records read data.
// Optional feature macro: JTAG_MBOX_TIMEOUT_EN adds a 255-cycle read-response
// timeout that returns 8'hEE and sets the tmo status flag.
module jtag_mbox_ctrl #(
    parameter int unsigned        IR_BITS    = 4,
    parameter logic [IR_BITS-1:0] MBOX_IR    = 4'hA,
    parameter int unsigned        FIFO_DEPTH = 4
) (
    input  logic               tck,
    input  logic               reset,
    input  logic [IR_BITS-1:0] ir,
    input  logic               capture_dr,
    input  logic               shift_dr,
    input  logic               update_dr,
    input  logic               tdi,
    output logic               tdo,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic               cmd_write,
    output logic [6:0]         cmd_addr,
    output logic [7:0]         cmd_wdata,
    input  logic               rsp_valid,
    input  logic [7:0]         rsp_rdata
);

    localparam int unsigned     PtrW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
    localparam logic [3:0]      LvlFull = 4'(FIFO_DEPTH);
    localparam logic [3:0]      LvlOne  = 4'd1;

    typedef enum logic [1:0] {StIdle, StIssue, StWaitRsp} state_e;

    state_e          state_q;
    logic [15:0]     sr_q, sr_d;
    logic [15:0]     mem [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [3:0]      level_q, level_d;
    logic [7:0]      last_rdata_q, last_rdata_d;
    logic            ovf_q, ovf_d, rdv_q, rdv_d, tmo_q, tmo_d;

    logic        sel, cap_sel, push_req, full, push, pop, ovf_set;
    logic        rsp_done, tmo_fire;
    logic [2:0]  lvl_sat;
    logic [15:0] status;
    logic [15:0] head;

    assign sel     = (ir == MBOX_IR);
    assign cap_sel = sel && capture_dr;
    assign tdo     = sel ? sr_q[0] : 1'b0;

    // Full is judged on the registered level, so a same-cycle pop cannot make room.
    assign push_req = sel && update_dr;
    assign full     = (level_q == LvlFull);
    assign push     = push_req && !full;
    assign ovf_set  = push_req && full;
    assign pop      = (state_q == StIdle) && (level_q != 4'd0);
    assign head     = mem[rd_ptr_q];
    assign rsp_done = (state_q == StWaitRsp) && rsp_valid;

`ifdef JTAG_MBOX_TIMEOUT_EN
    logic [7:0] tmo_cnt_q;
    // Count 0..254 is the 255th cycle without a response.
    assign tmo_fire = (state_q == StWaitRsp) && !rsp_valid && (tmo_cnt_q == 8'd254);
`else
    assign tmo_fire = 1'b0;
`endif

    // Status word and shift-register next state; capture has priority over shift.
    always_comb begin
        lvl_sat = (level_q > 4'd7) ? 3'd7 : level_q[2:0];
        status  = {last_rdata_q, ovf_q, rdv_q, lvl_sat, tmo_q, 2'b01};
        sr_d    = sr_q;
        if (cap_sel) begin
            sr_d = status;
        end else if (sel && shift_dr) begin
            sr_d = {tdi, sr_q[15:1]};
        end
    end

    // FIFO pointer/level and sticky flag next state; set events beat capture clears.
    always_comb begin
        wr_ptr_d     = push ? (wr_ptr_q + PtrOne) : wr_ptr_q;
        rd_ptr_d     = pop ? (rd_ptr_q + PtrOne) : rd_ptr_q;
        level_d      = level_q;
        if (push && !pop) begin
            level_d = level_q + LvlOne;
        end else if (pop && !push) begin
            level_d = level_q - LvlOne;
        end
        ovf_d        = ovf_set | (ovf_q & ~cap_sel);
        rdv_d        = rsp_done | tmo_fire | (rdv_q & ~cap_sel);
        tmo_d        = tmo_fire | (tmo_q & ~cap_sel);
        last_rdata_d = last_rdata_q;
        if (rsp_done) begin
            last_rdata_d = rsp_rdata;
        end else if (tmo_fire) begin
            last_rdata_d = 8'hEE;
        end
    end

    // Datapath registers: shift register, FIFO pointers, status flags.
    always_ff @(posedge tck) begin
        if (reset) begin
            sr_q         <= 16'h0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= 4'd0;
            last_rdata_q <= 8'h0;
            ovf_q        <= 1'b0;
            rdv_q        <= 1'b0;
            tmo_q        <= 1'b0;
        end else begin
            sr_q         <= sr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            last_rdata_q <= last_rdata_d;
            ovf_q        <= ovf_d;
            rdv_q        <= rdv_d;
            tmo_q        <= tmo_d;
        end
    end

    // FIFO storage is left unreset; only the pointers define its contents.
    always_ff @(posedge tck) begin
        if (push) begin
            mem[wr_ptr_q] <= sr_q;
        end
    end

    // Drain FSM with registered command outputs; every command returns through idle.
    always_ff @(posedge tck) begin
        if (reset) begin
            state_q   <= StIdle;
            cmd_valid <= 1'b0;
            cmd_write <= 1'b0;
            cmd_addr  <= 7'h0;
            cmd_wdata <= 8'h0;
`ifdef JTAG_MBOX_TIMEOUT_EN
            tmo_cnt_q <= 8'd0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        cmd_valid <= 1'b1;
                        cmd_write <= head[15];
                        cmd_addr  <= head[14:8];
                        cmd_wdata <= head[7:0];
                        state_q   <= StIssue;
                    end
                end
                StIssue: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state_q   <= cmd_write ? StIdle : StWaitRsp;
`ifdef JTAG_MBOX_TIMEOUT_EN
                        tmo_cnt_q <= 8'd0;
`endif
                    end
                end
                StWaitRsp: begin
                    if (rsp_done || tmo_fire) begin
                        state_q <= StIdle;
                    end
`ifdef JTAG_MBOX_TIMEOUT_EN
                    else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
